// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: state encoding,
// pointer width and the rotating-priority winner search.
package rr_arb_pkg;

  localparam int RR_MAX_N  = 64;
  localparam int RR_IDX_W  = $clog2(RR_MAX_N);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } st_t;

  function automatic int rr_ptr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // One-hot winner: first set bit of req at ptr, ptr+1, ... wrapping at n.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input int unsigned        ptr,
                                                  input int unsigned        n);
    logic [RR_MAX_N-1:0] gnt;
    logic                found;
    int unsigned         idx;
    logic [RR_IDX_W-1:0] bit_idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        bit_idx = idx[RR_IDX_W-1:0];
        if (!found && req[bit_idx]) begin
          gnt[bit_idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mux.sv
// Common one-hot AND-OR multiplexer; i_sel must be one-hot or zero.
module mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]        i_sel,
  input  logic [N-1:0][W-1:0] i_data,
  output logic [W-1:0]        o_data
);

  always_comb begin
    o_data = '0;
    for (int j = 0; j < N; j++) begin
      o_data = o_data | ({W{i_sel[j]}} & i_data[j]);
    end
  end

endmodule

// File: rtl/rr_arb_skid.sv
// Two-entry registered output slice; in_rdy_o comes from a flop, so the
// downstream ready never reaches the upstream ready combinationally.
module rr_arb_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_rdy_i
);

  logic         out_vld_q;
  logic [W-1:0] out_data_q;
  logic         skid_vld_q;
  logic [W-1:0] skid_data_q;
  logic         out_free;

  assign in_rdy_o   = ~skid_vld_q;
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;
  assign out_free   = ~out_vld_q | out_rdy_i;

  // Skid entry only fills when the output stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_data_q <= skid_data_q;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q  <= in_vld_i;
        out_data_q <= in_data_i;
      end
    end else if (in_vld_i && !skid_vld_q) begin
      skid_vld_q  <= 1'b1;
      skid_data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbiter with packet locking in front of a one-hot mux.
// Define RR_ARB_MUX_OUT_REG_EN to add a registered output slice (1-cycle latency).
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_req_vld,
  input  logic [N-1:0][W-1:0] i_req_data,
  input  logic [N-1:0]        i_req_last,
  output logic [N-1:0]        o_req_rdy,
  output logic                o_vld,
  output logic [W-1:0]        o_data,
  output logic                o_last,
  input  logic                i_rdy,
  output logic [N-1:0]        o_gnt
);

  localparam int PW = rr_ptr_width(N);

  st_t                 st_q, st_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       lock_q, lock_d;
  logic [PW-1:0]       win_idx;
  logic [N-1:0]        gnt;
  logic [RR_MAX_N-1:0] pick_full;
  logic                unused_pick;
  logic [N-1:0][W:0]   mux_in;
  logic [W:0]          mux_out;
  logic                int_vld;
  logic                int_rdy;
  logic                accept;
  logic                sel_last;

  assign pick_full   = rr_pick(RR_MAX_N'(i_req_vld), 32'(ptr_q), N);
  assign unused_pick = |pick_full;

  always_comb begin
    if (rst) begin
      gnt = '0;
    end else if (st_q == LOCKED) begin
      gnt = {{(N-1){1'b0}}, 1'b1} << lock_q;
    end else begin
      gnt = pick_full[N-1:0];
    end
  end

  always_comb begin
    win_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (gnt[j]) win_idx = PW'(j);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_mux_in
    assign mux_in[g] = {i_req_last[g], i_req_data[g]};
  end

  mux #(.N(N), .W(W + 1)) u_mux (
    .i_sel  (gnt),
    .i_data (mux_in),
    .o_data (mux_out)
  );

  assign sel_last  = mux_out[W];
  assign int_vld   = |(gnt & i_req_vld);
  assign accept    = int_vld & int_rdy;
  assign o_req_rdy = gnt & {N{int_rdy}};
  assign o_gnt     = gnt;

`ifdef RR_ARB_MUX_OUT_REG_EN
  logic         slice_vld;
  logic [W:0]   slice_data;

  rr_arb_skid #(.W(W + 1)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (int_vld),
    .in_data_i  (mux_out),
    .in_rdy_o   (int_rdy),
    .out_vld_o  (slice_vld),
    .out_data_o (slice_data),
    .out_rdy_i  (i_rdy)
  );

  assign o_vld  = slice_vld & ~rst;
  assign o_data = slice_data[W-1:0];
  assign o_last = slice_data[W] & slice_vld & ~rst;
`else
  assign int_rdy = i_rdy;
  assign o_vld   = int_vld;
  assign o_data  = mux_out[W-1:0];
  assign o_last  = sel_last;
`endif

  // Wrap is an explicit compare so non-power-of-two N rotates correctly.
  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    if (accept) begin
      if (st_q == IDLE) begin
        if (sel_last) begin
          ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          st_d   = LOCKED;
          lock_d = win_idx;
        end
      end else if (sel_last) begin
        st_d  = IDLE;
        ptr_d = (lock_q == PW'(N - 1)) ? '0 : lock_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      ptr_q  <= '0;
      lock_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
    end
  end

endmodule
